// File: rtl/mux_rr_reg.sv
// Registered N:1 multiplexer with valid/ready handshakes on every channel and on the output.
// The grant comes either from an explicit select or from a round-robin search among requesters.
module mux_rr_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       i_ready,
  output logic [WIDTH-1:0]          o,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [SEL_W-1:0]          o_channel
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] hi_idx, lo_idx, gidx;
  logic             hi_hit, lo_hit, sel_hit;
  logic             grant, slot_free, load;
  logic [WIDTH-1:0] gdata;

  // Round-robin: lowest requester at or above ptr wins; else lowest requester below ptr.
  always_comb begin
    hi_hit  = 1'b0;
    lo_hit  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    sel_hit = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (i_valid[k]) begin
        if (k >= int'(ptr_q)) begin
          hi_hit = 1'b1;
          hi_idx = SEL_W'(k);
        end else begin
          lo_hit = 1'b1;
          lo_idx = SEL_W'(k);
        end
      end
    end
    // An out-of-range select matches no channel, so it never grants.
    for (int k = 0; k < CHANNELS; k++) begin
      if (select == SEL_W'(k) && i_valid[k]) sel_hit = 1'b1;
    end
  end

  always_comb begin
    grant     = mode ? (hi_hit || lo_hit) : sel_hit;
    gidx      = mode ? (hi_hit ? hi_idx : lo_idx) : select;
    slot_free = !o_valid || o_ready;
    load      = !reset && slot_free && grant;
    i_ready   = '0;
    gdata     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gidx == SEL_W'(k)) begin
        i_ready[k] = load;
        gdata      = i[k*WIDTH +: WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (load && mode) begin
      ptr_d = (gidx == SEL_W'(CHANNELS - 1)) ? '0 : gidx + SEL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o         <= '0;
      o_valid   <= 1'b0;
      o_channel <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        o         <= gdata;
        o_channel <= gidx;
        o_valid   <= 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: a 4-channel and a 3-channel instance, checked each cycle against a
// transaction-level model, plus directed expectations for the key sequences.
module tb_mux_rr_reg;

  logic       clock = 1'b0;
  logic       rst;
  logic       md   [2];
  logic [1:0] sel  [2];
  logic [3:0] iv   [2];
  logic       ordy [2];
  logic [7:0] din  [2][4];

  logic [31:0] i4;
  logic [23:0] i3;
  logic [3:0]  rdy4;
  logic [2:0]  rdy3;
  logic [7:0]  o4, o3;
  logic        v4, v3;
  logic [1:0]  ch4, ch3;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, per instance.
  logic [7:0] m_o   [2];
  logic       m_v   [2];
  int         m_ch  [2];
  int         m_ptr [2];
  bit         started = 1'b0;

  always #5 clock = ~clock;

  assign i4 = {din[0][3], din[0][2], din[0][1], din[0][0]};
  assign i3 = {din[1][2], din[1][1], din[1][0]};

  mux_rr_reg #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clock(clock), .reset(rst), .mode(md[0]), .select(sel[0]), .i(i4), .i_valid(iv[0]),
    .i_ready(rdy4), .o(o4), .o_valid(v4), .o_ready(ordy[0]), .o_channel(ch4)
  );

  mux_rr_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clock(clock), .reset(rst), .mode(md[1]), .select(sel[1]), .i(i3), .i_valid(iv[1][2:0]),
    .i_ready(rdy3), .o(o3), .o_valid(v3), .o_ready(ordy[1]), .o_channel(ch3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Granted channel for the given request state, or -1 when nobody is granted.
  function automatic int pick(input int c, input logic m, input int s, input int p,
                              input logic [3:0] v);
    if (!m) return (s < c && v[s]) ? s : -1;
    for (int n = 0; n < c; n++) begin
      if (v[(p + n) % c]) return (p + n) % c;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      int c, g;
      c = (d == 0) ? 4 : 3;
      if (rst) begin
        m_o[d] = 8'h00; m_v[d] = 1'b0; m_ch[d] = 0; m_ptr[d] = 0;
        started = 1'b1;
      end else begin
        g = pick(c, md[d], int'(sel[d]), m_ptr[d], iv[d]);
        if ((!m_v[d] || ordy[d]) && g >= 0) begin
          m_o[d] = din[d][g]; m_ch[d] = g; m_v[d] = 1'b1;
          if (md[d]) m_ptr[d] = (g + 1) % c;
        end else if (m_v[d] && ordy[d]) begin
          m_v[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        int c, g;
        logic [3:0] er;
        c  = (d == 0) ? 4 : 3;
        g  = pick(c, md[d], int'(sel[d]), m_ptr[d], iv[d]);
        er = (!rst && (!m_v[d] || ordy[d]) && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("model d%0d o", d), (d == 0) ? o4 : o3, m_o[d]);
        chk($sformatf("model d%0d o_valid", d), (d == 0) ? v4 : v3, m_v[d]);
        chk($sformatf("model d%0d o_channel", d), (d == 0) ? ch4 : ch3, m_ch[d]);
        chk($sformatf("model d%0d i_ready", d), (d == 0) ? rdy4 : {1'b0, rdy3}, er);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int exp4 [6] = '{0, 1, 2, 3, 0, 1};
  int exp3 [6] = '{0, 1, 2, 0, 1, 2};
  int spr  [3] = '{3, 1, 3};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      md[d] = 1'b1; sel[d] = 2'd0; iv[d] = 4'hf; ordy[d] = 1'b1;
      for (int k = 0; k < 4; k++) din[d][k] = 8'(8'h11 * (k + 1));
    end

    step(); step();
    chk("reset o", o4, 8'h00);
    chk("reset o_valid", v4, 1'b0);
    chk("reset o_channel", ch4, 2'd0);
    chk("reset o_valid c3", v3, 1'b0);
    chk("reset i_ready", rdy4, 4'b0000);
    chk("reset i_ready c3", rdy3, 3'b000);
    rst = 1'b0;
    #1;
    chk("first rr grant", rdy4, 4'b0001);
    chk("first rr grant c3", rdy3, 3'b001);

    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair channel", ch4, exp4[k]);
      chk("fair data", o4, 8'(8'h11 * (exp4[k] + 1)));
      chk("fair valid", v4, 1'b1);
      chk("wrap channel c3", ch3, exp3[k]);
    end
    iv[0] = 4'b1010;

    for (int k = 0; k < 3; k++) begin
      step();
      chk("sparse channel", ch4, spr[k]);
      chk("sparse data", o4, 8'(8'h11 * (spr[k] + 1)));
    end
    md[0] = 1'b0;
    iv[0] = 4'hf;

    for (int s = 0; s < 4; s++) begin
      sel[0] = 2'(s);
      step();
      chk("sweep data", o4, 8'(8'h11 * (s + 1)));
      chk("sweep channel", ch4, s);
    end

    md[0]   = 1'b1;
    ordy[0] = 1'b0;
    #1;
    chk("bp i_ready", rdy4, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp data hold", o4, 8'h44);
      chk("bp valid hold", v4, 1'b1);
      chk("bp i_ready", rdy4, 4'b0000);
    end
    ordy[0] = 1'b1;
    #1;
    chk("bp release grant", rdy4, 4'b0001);
    step();
    chk("bp reload data", o4, 8'h11);
    chk("bp reload valid", v4, 1'b1);
    step();
    chk("bp next channel", ch4, 2'd1);

    md[1]  = 1'b0;
    sel[1] = 2'd3;
    #1;
    chk("oob select i_ready", rdy3, 3'b000);
    step();
    chk("oob select drain", v3, 1'b0);
    step();
    chk("oob select idle", v3, 1'b0);

    rst = 1'b1;
    step();
    chk("reset in flight valid", v4, 1'b0);
    chk("reset in flight data", o4, 8'h00);
    rst = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
